// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Brief    : Synchronous up/down counter with programmable modulus, wrap or
//            saturate behaviour at the boundaries, clock-enable prescaler,
//            clamped parallel load, terminal-count pulse and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_pre_last;
    logic             w_step;
    logic             w_boundary;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_load_val;

    // Prescaler: a step is taken on every PRESCALE-th enabled cycle. The
    // phase counter only advances when enabled, so gaps in enable never
    // discard accumulated progress.
    generate
        if (PRESCALE > 1) begin : g_prescale
            localparam int unsigned      PRE_W      = $clog2(PRESCALE);
            localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(PRESCALE - 1);

            logic [PRE_W-1:0] r_pre;

            // Phase counter, restarted by reset, clear and load
            always_ff @(posedge clk) begin
                if (reset || clear || load) begin
                    r_pre <= '0;
                end else if (enable) begin
                    r_pre <= (r_pre == c_pre_last) ? '0 : r_pre + PRE_W'(1);
                end
            end

            assign w_pre_last = (r_pre == c_pre_last);
        end else begin : g_no_prescale
            assign w_pre_last = 1'b1;
        end
    endgenerate

    assign w_step = enable && w_pre_last;

    // Load value is clamped so the count can never leave 0..MAX_VAL
    assign w_load_val = (load_value > c_max) ? c_max : load_value;

    // Next count for a step in the sampled direction, including boundary handling
    always_comb begin
        w_boundary = 1'b0;
        w_step_val = r_count;
        if (up_down) begin
            w_boundary = (r_count == c_max);
            if (w_boundary) begin
                w_step_val = SATURATE ? c_max : c_zero;
            end else begin
                w_step_val = r_count + WIDTH'(1);
            end
        end else begin
            w_boundary = (r_count == c_zero);
            if (w_boundary) begin
                w_step_val = SATURATE ? c_zero : c_max;
            end else begin
                w_step_val = r_count - WIDTH'(1);
            end
        end
    end

    // Count register: reset/clear, then load, then step
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= w_load_val;
        end else if (w_step) begin
            r_count <= w_step_val;
        end
    end

    // Terminal-count pulse: high only in the cycle after a boundary step
    always_ff @(posedge clk) begin
        if (reset || clear || load) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_step && w_boundary;
        end
    end

    // Sticky overflow: a boundary event outranks a simultaneous ovf_clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_ovf <= 1'b0;
        end else if (!load && w_step && w_boundary) begin
            r_ovf <= 1'b1;
        end else if (ovf_clear) begin
            r_ovf <= 1'b0;
        end
    end

    assign counter_out = r_count;
    assign tc          = r_tc;
    assign ovf_sticky  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_mod_counter
// Brief    : Directed self-checking bench for updown_mod_counter. Four
//            instances with different parameter sets share one stimulus bus;
//            each scenario checks the instance it targets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic       clear;
    logic       load;
    logic [7:0] load_value;
    logic       ovf_clear;

    logic [3:0] leg_cnt;
    logic       leg_tc;
    logic       leg_ovf;
    logic [7:0] wr_cnt;
    logic       wr_tc;
    logic       wr_ovf;
    logic [7:0] sa_cnt;
    logic       sa_tc;
    logic       sa_ovf;
    logic [7:0] pr_cnt;
    logic       pr_tc;
    logic       pr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0), .PRESCALE(1)) u_leg (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value[3:0]), .ovf_clear(ovf_clear),
        .counter_out(leg_cnt), .tc(leg_tc), .ovf_sticky(leg_ovf)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clear(ovf_clear),
        .counter_out(wr_cnt), .tc(wr_tc), .ovf_sticky(wr_ovf)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clear(ovf_clear),
        .counter_out(sa_cnt), .tc(sa_tc), .ovf_sticky(sa_ovf)
    );

    updown_mod_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clear(ovf_clear),
        .counter_out(pr_cnt), .tc(pr_tc), .ovf_sticky(pr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset      = 1'b0;
        enable     = 1'b0;
        up_down    = 1'b1;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = 8'd0;
        ovf_clear  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({leg_cnt, leg_tc, leg_ovf} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL reset_leg: got cnt=%0d tc=%b ovf=%b, want 0 0 0", leg_cnt, leg_tc, leg_ovf);
        end
        n_checks++;
        if ({wr_cnt, wr_tc, wr_ovf, sa_cnt, sa_tc, sa_ovf, pr_cnt, pr_tc, pr_ovf} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_all: got wr=%0d/%b/%b sa=%0d/%b/%b pr=%0d/%b/%b, want all 0",
                     wr_cnt, wr_tc, wr_ovf, sa_cnt, sa_tc, sa_ovf, pr_cnt, pr_tc, pr_ovf);
        end
    endtask

    // Legacy settings must match a plain 4-bit free-running up counter
    task automatic test_legacy();
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic       exp_ovf;
        do_reset();
        enable  = 1'b1;
        up_down = 1'b1;
        exp_cnt = 4'd0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = exp_cnt + 4'd1;
            exp_tc  = (exp_cnt == 4'd0);
            if (exp_tc) exp_ovf = 1'b1;
            n_checks++;
            if ({leg_cnt, leg_tc, leg_ovf} !== {exp_cnt, exp_tc, exp_ovf}) begin
                n_fail++;
                $display("FAIL legacy[%0d]: got cnt=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, leg_cnt, leg_tc, leg_ovf, exp_cnt, exp_tc, exp_ovf);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_wrap_down();
        logic [7:0] exp_cnt [4] = '{8'd1, 8'd0, 8'd9, 8'd8};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        load       = 1'b1;
        load_value = 8'd2;
        tick();
        load = 1'b0;
        n_checks++;
        if (wr_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL wrap_load: got cnt=%0d, want 2", wr_cnt);
        end
        enable  = 1'b1;
        up_down = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({wr_cnt, wr_tc, wr_ovf} !== {exp_cnt[i], exp_tc[i], exp_ovf[i]}) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: got cnt=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, wr_cnt, wr_tc, wr_ovf, exp_cnt[i], exp_tc[i], exp_ovf[i]);
            end
        end
        enable    = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        n_checks++;
        if ({wr_cnt, wr_tc, wr_ovf} !== {8'd8, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_ovf_clear: got cnt=%0d tc=%b ovf=%b, want 8 0 0", wr_cnt, wr_tc, wr_ovf);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_cnt [4] = '{8'd9, 8'd9, 8'd9, 8'd9};
        logic       exp_tc  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_ovf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        load       = 1'b1;
        load_value = 8'd8;
        tick();
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Last step also asserts ovf_clear: the boundary set must win
            ovf_clear = (i == 3);
            tick();
            n_checks++;
            if ({sa_cnt, sa_tc, sa_ovf} !== {exp_cnt[i], exp_tc[i], exp_ovf[i]}) begin
                n_fail++;
                $display("FAIL sat_up[%0d]: got cnt=%0d tc=%b ovf=%b, want %0d %b %b",
                         i, sa_cnt, sa_tc, sa_ovf, exp_cnt[i], exp_tc[i], exp_ovf[i]);
            end
        end
        enable    = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        n_checks++;
        if ({sa_cnt, sa_tc, sa_ovf} !== {8'd9, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sat_ovf_clear: got cnt=%0d tc=%b ovf=%b, want 9 0 0", sa_cnt, sa_tc, sa_ovf);
        end
        // Down from 0 saturates at 0 and still flags a boundary
        do_reset();
        enable  = 1'b1;
        up_down = 1'b0;
        tick();
        enable = 1'b0;
        n_checks++;
        if ({sa_cnt, sa_tc, sa_ovf} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_down_zero: got cnt=%0d tc=%b ovf=%b, want 0 1 1", sa_cnt, sa_tc, sa_ovf);
        end
    endtask

    task automatic test_prescale();
        logic       en_pat  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp_cnt [7] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
        do_reset();
        up_down = 1'b1;
        for (int i = 0; i < 7; i++) begin
            enable = en_pat[i];
            tick();
            n_checks++;
            if ({pr_cnt, pr_tc} !== {exp_cnt[i], 1'b0}) begin
                n_fail++;
                $display("FAIL prescale[%0d]: got cnt=%0d tc=%b, want %0d 0", i, pr_cnt, pr_tc, exp_cnt[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        load       = 1'b1;
        load_value = 8'd3;
        tick();
        n_checks++;
        if (wr_cnt !== 8'd3) begin
            n_fail++;
            $display("FAIL prio_load3: got cnt=%0d, want 3", wr_cnt);
        end
        // reset, clear and load together
        reset      = 1'b1;
        clear      = 1'b1;
        load_value = 8'd5;
        tick();
        reset = 1'b0;
        clear = 1'b0;
        n_checks++;
        if (wr_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL prio_all: got cnt=%0d, want 0", wr_cnt);
        end
        // Load above MAX_VAL clamps
        load_value = 8'd200;
        tick();
        load = 1'b0;
        n_checks++;
        if (wr_cnt !== 8'd9) begin
            n_fail++;
            $display("FAIL prio_clamp: got cnt=%0d, want 9", wr_cnt);
        end
        // Up step from loaded MAX_VAL is a boundary
        enable  = 1'b1;
        up_down = 1'b1;
        tick();
        enable = 1'b0;
        n_checks++;
        if ({wr_cnt, wr_tc, wr_ovf} !== {8'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_max_step: got cnt=%0d tc=%b ovf=%b, want 0 1 1", wr_cnt, wr_tc, wr_ovf);
        end
        // Load during the tc cycle drops tc and leaves ovf alone
        load       = 1'b1;
        load_value = 8'd4;
        tick();
        n_checks++;
        if ({wr_cnt, wr_tc, wr_ovf} !== {8'd4, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL prio_load_tc: got cnt=%0d tc=%b ovf=%b, want 4 0 1", wr_cnt, wr_tc, wr_ovf);
        end
        // clear beats load
        clear      = 1'b1;
        load_value = 8'd5;
        tick();
        clear = 1'b0;
        load  = 1'b0;
        n_checks++;
        if ({wr_cnt, wr_tc, wr_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL prio_clear_load: got cnt=%0d tc=%b ovf=%b, want 0 0 0", wr_cnt, wr_tc, wr_ovf);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        enable  = 1'b1;
        up_down = 1'b1;
        // 21 enabled cycles reach 7 at phase 0; one more leaves phase 1
        for (int i = 0; i < 22; i++) tick();
        n_checks++;
        if (pr_cnt !== 8'd7) begin
            n_fail++;
            $display("FAIL midrst_pre: got cnt=%0d, want 7", pr_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({pr_cnt, pr_tc, pr_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_out: got cnt=%0d tc=%b ovf=%b, want 0 0 0", pr_cnt, pr_tc, pr_ovf);
        end
        tick();
        tick();
        n_checks++;
        if (pr_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_phase: got cnt=%0d after 2 enables, want 0", pr_cnt);
        end
        tick();
        n_checks++;
        if (pr_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL midrst_step: got cnt=%0d after 3 enables, want 1", pr_cnt);
        end
        enable = 1'b0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_legacy();
        test_wrap_down();
        test_saturate();
        test_prescale();
        test_priority();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to `first_counter`: a synchronous up/down counter with programmable modulus, wrap or saturate mode, a clock-enable prescaler, parallel load, a terminal-count pulse and a sticky overflow flag. It is the general-purpose event/timer counter for the design. With default-compatible settings it is a drop-in superset of `first_counter`: WIDTH=4, MAX_VAL=15, SATURATE=0, PRESCALE=1, up_down=1, load=clear=ovf_clear=0.

## Interface
- WIDTH, default 8: counter width in bits; legal range is 1 or more.
- MAX_VAL, default 2**WIDTH-1: highest count value; the count range is 0..MAX_VAL; legal range is 1..2**WIDTH-1.
- SATURATE, default 0: 0 means wrap at the boundaries; 1 means hold at the boundaries.
- PRESCALE, default 1: number of enabled cycles per count step; legal range is 1 or more.
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- enable  input  1  count enable; each enabled cycle feeds the prescaler.
- up_down  input  1  direction: 1 counts up, 0 counts down.
- clear  input  1  synchronous clear of count, prescaler and flags.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value to load; clamped to MAX_VAL.
- ovf_clear  input  1  clears ovf_sticky.
- counter_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf_sticky  output  1  set by any boundary event; held until cleared.

## Operation
- Internal state: count (WIDTH bits), pre_cnt (range 0..PRESCALE-1), tc register, ovf register.
- Priority per edge, highest first: reset, clear, load, count step.
- reset or clear: count=0, pre_cnt=0, tc=0, ovf_sticky=0.
- load: count=min(load_value, MAX_VAL); pre_cnt=0; tc=0; ovf_sticky is unchanged.
- enable=0 with no load/clear: everything holds, and tc goes to 0.
- enable=1 with pre_cnt<PRESCALE-1: pre_cnt increments; count holds.
- enable=1 with pre_cnt==PRESCALE-1: a step occurs and pre_cnt returns to 0. With PRESCALE=1, every enabled cycle is a step.
- Up step:
  - count<MAX_VAL: count+1.
  - count==MAX_VAL: boundary event; count becomes 0 (SATURATE=0) or stays at MAX_VAL (SATURATE=1).
- Down step:
  - count>0: count-1.
  - count==0: boundary event; count becomes MAX_VAL (SATURATE=0) or stays at 0 (SATURATE=1).
- Boundary event: tc is 1 for the following cycle, otherwise 0; ovf_sticky is set.
- ovf_clear clears ovf_sticky. If a boundary event and ovf_clear occur on the same edge, the set wins.
- All arithmetic is modulo the range 0..MAX_VAL. counter_out never exceeds MAX_VAL.
- up_down may change on any cycle. The direction used is the value sampled at the step edge.

## Timing
- Reset values: counter_out=0, tc=0, ovf_sticky=0. All outputs are registered, with no combinational input-to-output paths.
- Latency: a step sampled at edge N is visible on counter_out after edge N, together with any tc/ovf_sticky change.
- Reset is honoured on the first edge it is sampled, including mid-prescale and mid-sequence.
- Load during a tc cycle: tc goes to 0 on the next cycle.
- Load of MAX_VAL followed by an up step gives a boundary event on that step.
- Toggling enable mid-prescale does not lose progress: pre_cnt holds while enable=0.

## Test plan
- Legacy parameters (WIDTH=4, MAX_VAL=15, PRESCALE=1, SATURATE=0): reset, then enable for 20 cycles with up_down=1 -> counter_out goes 1,2,...,15,0,1,...; tc is high exactly in the cycle counter_out becomes 0; every cycle matches a golden `first_counter` model.
- MAX_VAL=9, SATURATE=0, down: load 2, then 4 enabled cycles -> 1,0,9,8; tc is high with the first 9; ovf_sticky=1 until ovf_clear, then 0.
- SATURATE=1, MAX_VAL=9, up: load 8, then 4 steps -> 9,9,9,9; tc pulses on each of the last three steps; ovf_clear asserted on a boundary step -> ovf_sticky stays 1.
- PRESCALE=3, up from 0: enable pattern 1,1,0,1,1,1,1 -> counter_out steps to 1 on the 4th enable (after the gap) and to 2 on the 7th.
- Priority: reset, clear and load asserted together with load_value=5 -> counter_out=0. Then load=1 with load_value=200 and MAX_VAL=9 -> 9. Then clear=1 and load=1 -> 0.
- Mid-operation reset: count to 7 with PRESCALE=3 and pre_cnt=1, assert reset for 1 cycle -> all outputs 0; the next step occurs only after 3 enabled cycles.
